enoc_node_interface: RTL and testbench
======================================

# enoc_node_interface

Per-node network interface between a traffic source/sink and one port pair of the ENoC mesh. On the injection side it buffers packets from the local source and presents them to the network under the valid/enable protocol. On the ejection side it accepts packets the network delivers to the node, buffers them and hands them to the local sink. One instance sits on each node index of the network.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries in each of the injection and ejection FIFOs; a power of two, ≥2.
- CNT_W, 16, width of the statistics counters.

Ports (packet_t is the codebase's packet type, carried opaquely and never modified):
- clk  in  1  the block's single clock; all state is registered on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_pkt  in  packet_t  packet from the local source.
- i_pkt_val  in  1  i_pkt is valid.
- o_pkt_rdy  out  1  injection FIFO can accept a packet.
- o_net_data  out  packet_t  packet to the network local input, taken from the head of the injection FIFO.
- o_net_data_val  out  1  o_net_data is valid.
- i_net_en  in  1  network accepts o_net_data this cycle.
- i_net_data  in  packet_t  packet from the network local output.
- i_net_data_val  in  1  i_net_data is valid.
- o_net_en  out  1  network may deliver a packet this cycle.
- o_rx_pkt  out  packet_t  packet to the local sink, taken from the head of the ejection FIFO.
- o_rx_pkt_val  out  1  o_rx_pkt is valid.
- i_rx_rdy  in  1  sink accepts o_rx_pkt.
- o_tx_count  out  CNT_W  packets accepted by the network.
- o_rx_count  out  CNT_W  packets accepted from the network.
- o_stall_count  out  CNT_W  cycles in which o_net_data_val=1 and i_net_en=0.

## Operation
- Transfer rule, every interface: a transfer occurs in a cycle only when the valid and the enable/ready signal are both 1 on the same rising edge.
  - If valid is 1 and enable is 0, the producer holds its data.
  - The consumer ignores data presented without its enable.
- Injection FIFO:
  - Push when i_pkt_val & o_pkt_rdy.
  - Pop when o_net_data_val & i_net_en.
  - o_pkt_rdy = !full.
  - o_net_data_val = !empty.
  - o_net_data = head entry.
- Ejection FIFO:
  - Push when i_net_data_val & o_net_en.
  - Pop when o_rx_pkt_val & i_rx_rdy.
  - o_net_en = !full.
  - o_rx_pkt_val = !empty.
  - o_rx_pkt = head entry.
- Each FIFO:
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - full means count==FIFO_DEPTH; empty means count==0.
- No bypass: the ready/enable signals depend only on registered occupancy, never on the same-cycle pop.
- Simultaneous events:
  - Push and pop in the same cycle when not empty and not full: count unchanged, both pointers advance.
  - When full, no push is possible, so only a pop occurs.
  - When empty, only the push occurs.
- Counters:
  - o_tx_count increments on each injection pop and wraps modulo 2^CNT_W.
  - o_rx_count increments on each ejection push and wraps modulo 2^CNT_W.
  - o_stall_count increments as specified and saturates at 2^CNT_W-1.
- Packet order is preserved in both directions. Packet contents pass through unaltered.

## Timing
- Reset asserted, asynchronous and immediate:
  - Pointers, counts and counters go to 0.
  - o_net_data_val=0, o_rx_pkt_val=0.
  - o_pkt_rdy=0 and o_net_en=0 while reset is high.
  - o_net_data and o_rx_pkt are don't-care.
- First cycle after reset deasserts: o_pkt_rdy=1, o_net_en=1.
- Reset mid-operation: all buffered packets are discarded and the counters are cleared. No partial transfer completes in a cycle where reset is high.
- Injection latency: a packet pushed at edge N is on o_net_data with o_net_data_val=1 after edge N, i.e. visible in cycle N+1. Minimum 1 cycle; there is no combinational path from i_pkt to o_net_data.
- Ejection latency: the same 1 cycle from i_net_data to o_rx_pkt.
- Throughput: one packet per cycle per direction when the downstream enable is held high.
- o_pkt_rdy falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- o_net_en follows the same rule on the ejection FIFO.
- Counters update on the same edge as the qualifying transfer and are visible the following cycle.

## Test plan
- Reset, then hold i_pkt_val=0 and i_net_data_val=0:
  - o_pkt_rdy=1, o_net_en=1, both valids 0, all counts 0.
  - While reset is high, o_pkt_rdy=0 and o_net_en=0.
- Push packets A, B, C on consecutive cycles with i_net_en=1:
  - A, B, C appear on o_net_data in cycles 2, 3, 4 with val=1.
  - o_tx_count=3.
- i_net_en=0, push 5 packets with FIFO_DEPTH=4:
  - o_pkt_rdy drops after the 4th push; the 5th is held by the source.
  - o_stall_count increments every cycle.
  - Raise i_net_en: the packets drain in order, and rdy returns one cycle after the first pop.
- Drive i_net_data_val=1 every cycle with i_rx_rdy=0:
  - o_net_en=0 after 4 accepts; o_rx_count=4.
  - Release i_rx_rdy: 4 packets come out in order.
- Assert reset with 3 packets buffered in each FIFO:
  - Both valids drop immediately and the counters go to 0.
  - After release, no stale packet appears.
- Preload o_tx_count to 2^CNT_W-1 (CNT_W=4, 15 transfers), then do one more transfer: o_tx_count=0.
  - Hold a stall for 20 cycles: o_stall_count=15, saturated.

Source files
------------

// File: rtl/enoc_node_interface.sv
// Node network interface for the ENoC mesh: buffers local injection traffic toward the
// network and network ejection traffic toward the local sink, with transfer statistics.

module enoc_node_fifo #(
    parameter int  DEPTH  = 4,
    parameter type data_t = logic [31:0]
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  data_t push_data,
    input  logic  pop,
    output data_t head,
    output logic  full,
    output logic  empty
);
    localparam int PTR_W = $clog2(DEPTH);

    data_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Storage needs no reset; pointers and occupancy alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module enoc_node_interface #(
    parameter int  FIFO_DEPTH = 4,
    parameter int  CNT_W      = 16,
    parameter type packet_t   = logic [31:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  packet_t          i_pkt,
    input  logic             i_pkt_val,
    output logic             o_pkt_rdy,
    output packet_t          o_net_data,
    output logic             o_net_data_val,
    input  logic             i_net_en,
    input  packet_t          i_net_data,
    input  logic             i_net_data_val,
    output logic             o_net_en,
    output packet_t          o_rx_pkt,
    output logic             o_rx_pkt_val,
    input  logic             i_rx_rdy,
    output logic [CNT_W-1:0] o_tx_count,
    output logic [CNT_W-1:0] o_rx_count,
    output logic [CNT_W-1:0] o_stall_count
);
    logic inj_full;
    logic inj_empty;
    logic inj_push;
    logic inj_pop;
    logic ej_full;
    logic ej_empty;
    logic ej_push;
    logic ej_pop;

    // Ready/enable come only from registered occupancy and are forced low during reset.
    assign o_pkt_rdy      = !inj_full && !reset;
    assign o_net_data_val = !inj_empty;
    assign o_net_en       = !ej_full && !reset;
    assign o_rx_pkt_val   = !ej_empty;

    assign inj_push = i_pkt_val && o_pkt_rdy;
    assign inj_pop  = o_net_data_val && i_net_en;
    assign ej_push  = i_net_data_val && o_net_en;
    assign ej_pop   = o_rx_pkt_val && i_rx_rdy;

    enoc_node_fifo #(
        .DEPTH (FIFO_DEPTH),
        .data_t(packet_t)
    ) u_inj_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inj_push),
        .push_data(i_pkt),
        .pop      (inj_pop),
        .head     (o_net_data),
        .full     (inj_full),
        .empty    (inj_empty)
    );

    enoc_node_fifo #(
        .DEPTH (FIFO_DEPTH),
        .data_t(packet_t)
    ) u_ej_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (ej_push),
        .push_data(i_net_data),
        .pop      (ej_pop),
        .head     (o_rx_pkt),
        .full     (ej_full),
        .empty    (ej_empty)
    );

    // Transfer counters wrap; the stall counter saturates so long stalls stay visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_tx_count    <= '0;
            o_rx_count    <= '0;
            o_stall_count <= '0;
        end else begin
            if (inj_pop) begin
                o_tx_count <= o_tx_count + 1'b1;
            end
            if (ej_push) begin
                o_rx_count <= o_rx_count + 1'b1;
            end
            if (o_net_data_val && !i_net_en && (o_stall_count != '1)) begin
                o_stall_count <= o_stall_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_enoc_node_interface.sv
// Self-checking bench for enoc_node_interface: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.

module tb_enoc_node_interface;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [15:0] pkt_t;

    logic             clk = 1'b0;
    logic             reset;
    pkt_t             i_pkt;
    logic             i_pkt_val;
    logic             o_pkt_rdy;
    pkt_t             o_net_data;
    logic             o_net_data_val;
    logic             i_net_en;
    pkt_t             i_net_data;
    logic             i_net_data_val;
    logic             o_net_en;
    pkt_t             o_rx_pkt;
    logic             o_rx_pkt_val;
    logic             i_rx_rdy;
    logic [CNT_W-1:0] o_tx_count;
    logic [CNT_W-1:0] o_rx_count;
    logic [CNT_W-1:0] o_stall_count;

    int checks   = 0;
    int failures = 0;

    pkt_t inj_q[$];
    pkt_t ej_q[$];
    int   tx_model;
    int   rx_model;
    int   stall_model;

    enoc_node_interface #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CNT_W),
        .packet_t  (pkt_t)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pkt         (i_pkt),
        .i_pkt_val     (i_pkt_val),
        .o_pkt_rdy     (o_pkt_rdy),
        .o_net_data    (o_net_data),
        .o_net_data_val(o_net_data_val),
        .i_net_en      (i_net_en),
        .i_net_data    (i_net_data),
        .i_net_data_val(i_net_data_val),
        .o_net_en      (o_net_en),
        .o_rx_pkt      (o_rx_pkt),
        .o_rx_pkt_val  (o_rx_pkt_val),
        .i_rx_rdy      (i_rx_rdy),
        .o_tx_count    (o_tx_count),
        .o_rx_count    (o_rx_count),
        .o_stall_count (o_stall_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkState();
        checkOutput("pkt_rdy", 32'(o_pkt_rdy), 32'(inj_q.size() < DEPTH));
        checkOutput("net_data_val", 32'(o_net_data_val), 32'(inj_q.size() != 0));
        if (inj_q.size() != 0) checkOutput("net_data", 32'(o_net_data), 32'(inj_q[0]));
        checkOutput("net_en", 32'(o_net_en), 32'(ej_q.size() < DEPTH));
        checkOutput("rx_pkt_val", 32'(o_rx_pkt_val), 32'(ej_q.size() != 0));
        if (ej_q.size() != 0) checkOutput("rx_pkt", 32'(o_rx_pkt), 32'(ej_q[0]));
        checkOutput("tx_count", 32'(o_tx_count), 32'(tx_model % (CNT_MAX + 1)));
        checkOutput("rx_count", 32'(o_rx_count), 32'(rx_model % (CNT_MAX + 1)));
        checkOutput("stall_count", 32'(o_stall_count), 32'(stall_model));
    endtask

    // Called on a falling edge: check the model against the DUT, drive one cycle of
    // inputs, advance the model by what that rising edge transfers.
    task automatic applyStimulus(input bit pv, input pkt_t pd, input bit ne,
                                 input bit nv, input pkt_t nd, input bit rr);
        bit inj_push, inj_pop, ej_push, ej_pop;
        #1;
        checkState();
        i_pkt_val      = pv;
        i_pkt          = pd;
        i_net_en       = ne;
        i_net_data_val = nv;
        i_net_data     = nd;
        i_rx_rdy       = rr;
        inj_push = pv && (inj_q.size() < DEPTH);
        inj_pop  = ne && (inj_q.size() != 0);
        ej_push  = nv && (ej_q.size() < DEPTH);
        ej_pop   = rr && (ej_q.size() != 0);
        if (inj_q.size() != 0 && !ne && stall_model < CNT_MAX) stall_model++;
        if (inj_pop) begin
            void'(inj_q.pop_front());
            tx_model++;
        end
        if (inj_push) inj_q.push_back(pd);
        if (ej_pop) void'(ej_q.pop_front());
        if (ej_push) begin
            ej_q.push_back(nd);
            rx_model++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ne, input bit rr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ne, 1'b0, '0, rr);
    endtask

    // Asserts reset between edges so its effect is seen without any clock.
    task automatic doReset();
        i_pkt_val      = 1'b0;
        i_net_data_val = 1'b0;
        i_net_en       = 1'b0;
        i_rx_rdy       = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_pkt_rdy", 32'(o_pkt_rdy), 32'd0);
        checkOutput("rst_net_en", 32'(o_net_en), 32'd0);
        checkOutput("rst_net_val", 32'(o_net_data_val), 32'd0);
        checkOutput("rst_rx_val", 32'(o_rx_pkt_val), 32'd0);
        checkOutput("rst_tx_count", 32'(o_tx_count), 32'd0);
        checkOutput("rst_rx_count", 32'(o_rx_count), 32'd0);
        checkOutput("rst_stall_count", 32'(o_stall_count), 32'd0);
        inj_q.delete();
        ej_q.delete();
        tx_model    = 0;
        rx_model    = 0;
        stall_model = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        pkt_t p;
        reset          = 1'b1;
        i_pkt          = '0;
        i_pkt_val      = 1'b0;
        i_net_en       = 1'b0;
        i_net_data     = '0;
        i_net_data_val = 1'b0;
        i_rx_rdy       = 1'b0;
        @(negedge clk);
        doReset();
        idle(2, 1'b0, 1'b0);

        // Three packets back to back with the network accepting.
        doReset();
        applyStimulus(1'b1, 16'hA00A, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 16'hB00B, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 16'hC00C, 1'b1, 1'b0, '0, 1'b0);
        idle(3, 1'b1, 1'b0);
        checkOutput("abc_tx_count", 32'(o_tx_count), 32'd3);

        // Fill the injection FIFO while the network refuses, then drain.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, pkt_t'(16'h5000 + i), 1'b0, 1'b0, '0, 1'b0);
        checkOutput("inj_full_rdy", 32'(o_pkt_rdy), 32'd0);
        applyStimulus(1'b1, 16'h5004, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("inj_full_stall", 32'(o_stall_count), 32'd4);
        for (int i = 0; i < 8 && inj_q.size() >= DEPTH; i++)
            applyStimulus(1'b1, 16'h5004, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 16'h5004, 1'b1, 1'b0, '0, 1'b0);
        idle(6, 1'b1, 1'b0);

        // Fill the ejection FIFO while the sink refuses, then release it.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, pkt_t'(16'h7000 + i), 1'b0);
        checkOutput("ej_full_en", 32'(o_net_en), 32'd0);
        checkOutput("ej_full_rx_count", 32'(o_rx_count), 32'd4);
        idle(6, 1'b0, 1'b1);

        // Reset with three packets buffered each way.
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, pkt_t'(16'h9000 + i), 1'b0, 1'b1, pkt_t'(16'h9100 + i), 1'b0);
        checkOutput("pre_rst_net_val", 32'(o_net_data_val), 32'd1);
        doReset();
        idle(4, 1'b1, 1'b1);

        // Transfer counter wrap and stall counter saturation.
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, pkt_t'(16'h3000 + i), 1'b1, 1'b0, '0, 1'b0);
        checkOutput("tx_preload", 32'(o_tx_count), 32'd15);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("tx_wrap", 32'(o_tx_count), 32'd0);
        applyStimulus(1'b1, 16'h3FFF, 1'b0, 1'b0, '0, 1'b0);
        idle(20, 1'b0, 1'b0);
        checkOutput("stall_sat", 32'(o_stall_count), 32'd15);
        idle(3, 1'b1, 1'b0);

        // Random traffic in both directions.
        doReset();
        for (int i = 0; i < 400; i++) begin
            p = pkt_t'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) != 0, pkt_t'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(8, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
